// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: width codes,
// controller state encoding, MMIO window base and the alignment rule.
package dmem_access_ctrl_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [31:0] DEFAULT_MMIO_BASE = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BRAM_RD   = 2'd1,
    ST_MMIO_WAIT = 2'd2
  } dmem_state_e;

  // Halfwords need an even address, words a 4-byte aligned one; bytes never trap.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis_v;
    case (f3[1:0])
      2'b01:   mis_v = off[0];
      2'b10:   mis_v = (off != 2'b00);
      default: mis_v = 1'b0;
    endcase
    return mis_v;
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_timeout_ctr.sv
// Wait-cycle counter for MMIO handshakes: clear, enable and a terminal flag
// that is raised on the last permitted wait cycle.
module mmio_timeout_ctr #(
  parameter int TERMINAL = 254
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic term
);

  localparam int CW = (TERMINAL < 1) ? 1 : $clog2(TERMINAL + 1);

  logic [CW-1:0] cnt_r;

  // Count enabled wait cycles; any cycle outside a wait restarts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (en) begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign term = en & (cnt_r == CW'(TERMINAL));

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data port controller: single-cycle BRAM port-B accesses, stalled
// MMIO handshakes with timeout, raw load word return and misalignment flag.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int          DMEM_AW      = 12,
  parameter logic [31:0] MMIO_BASE    = DEFAULT_MMIO_BASE,
  parameter int          MMIO_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [31:0]        addr,
  input  logic [2:0]         funct3,
  input  logic [3:0]         web_in,
  input  logic [31:0]        dib_in,
  output logic               enb,
  output logic [3:0]         web,
  output logic [DMEM_AW-1:0] addrb,
  output logic [31:0]        dib,
  input  logic [31:0]        doutb,
  output logic               mmio_valid,
  output logic [3:0]         mmio_we,
  output logic [31:0]        mmio_addr,
  output logic [31:0]        mmio_wdata,
  input  logic [31:0]        mmio_rdata,
  input  logic               mmio_ready,
  output logic               stall,
  output logic [31:0]        DMEM_word,
  output logic [1:0]         byte_offset_q,
  output logic [2:0]         funct3_q,
  output logic               rd_valid,
  output logic               misaligned,
  output logic               bus_err
);

  dmem_state_e state_r;
  logic        cmpl_r;
  logic        mmio_rd_r;
  logic        mmio_rdv_r;
  logic        bus_err_r;
  logic        mmio_valid_r;
  logic [3:0]  mmio_we_r;
  logic [31:0] mmio_addr_r;
  logic [31:0] mmio_wdata_r;
  logic [31:0] word_r;
  logic [1:0]  boff_r;
  logic [2:0]  f3_r;

  logic req_s, mmio_s, mis_s, go_s, bram_go_s, bram_wr_s;
  logic wait_s, rd_s, term_s;

  // The cycle after an MMIO completion the finished instruction is still in
  // MEM with its request held, so cmpl_r keeps it from being issued twice.
  assign req_s     = ~rst & (state_r == ST_IDLE) & ~cmpl_r & (mem_read | mem_write);
  assign mmio_s    = (addr >= MMIO_BASE);
  assign mis_s     = is_misaligned(funct3, addr[1:0]);
  assign go_s      = req_s & ~mis_s;
  assign bram_go_s = go_s & ~mmio_s;
  assign bram_wr_s = bram_go_s & mem_write;
  assign wait_s    = ~rst & (state_r == ST_MMIO_WAIT);
  assign rd_s      = ~rst & (state_r == ST_BRAM_RD);

  assign enb   = bram_go_s;
  assign web   = bram_wr_s ? web_in : 4'h0;
  assign dib   = bram_wr_s ? dib_in : 32'h0;
  assign addrb = bram_go_s ? addr[DMEM_AW+1:2] : {DMEM_AW{1'b0}};

  assign stall      = (go_s & (mmio_s | ~mem_write)) | wait_s;
  assign misaligned = req_s & mis_s;

  assign DMEM_word     = rst ? 32'h0 : (rd_s ? doutb : word_r);
  assign rd_valid      = rd_s | mmio_rdv_r;
  assign byte_offset_q = boff_r;
  assign funct3_q      = f3_r;
  assign bus_err       = bus_err_r;

  assign mmio_valid = mmio_valid_r;
  assign mmio_we    = mmio_we_r;
  assign mmio_addr  = mmio_addr_r;
  assign mmio_wdata = mmio_wdata_r;

  mmio_timeout_ctr #(
    .TERMINAL (MMIO_TIMEOUT - 1)
  ) u_timeout (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_r != ST_MMIO_WAIT),
    .en   (state_r == ST_MMIO_WAIT),
    .term (term_s)
  );

  // Access sequencing: state, MMIO request registers and load result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cmpl_r       <= 1'b0;
      mmio_rd_r    <= 1'b0;
      mmio_rdv_r   <= 1'b0;
      bus_err_r    <= 1'b0;
      mmio_valid_r <= 1'b0;
      mmio_we_r    <= 4'h0;
      mmio_addr_r  <= 32'h0;
      mmio_wdata_r <= 32'h0;
      word_r       <= 32'h0;
      boff_r       <= 2'b00;
      f3_r         <= 3'b000;
    end else begin
      cmpl_r     <= 1'b0;
      mmio_rdv_r <= 1'b0;
      bus_err_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (go_s && mmio_s) begin
            state_r      <= ST_MMIO_WAIT;
            mmio_valid_r <= 1'b1;
            mmio_addr_r  <= addr;
            mmio_we_r    <= mem_write ? web_in : 4'h0;
            mmio_wdata_r <= mem_write ? dib_in : 32'h0;
            mmio_rd_r    <= ~mem_write;
            if (!mem_write) begin
              boff_r <= addr[1:0];
              f3_r   <= funct3;
            end
          end else if (go_s && !mem_write) begin
            state_r <= ST_BRAM_RD;
            boff_r  <= addr[1:0];
            f3_r    <= funct3;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BRAM_RD: begin
          word_r  <= doutb;
          state_r <= ST_IDLE;
        end
        ST_MMIO_WAIT: begin
          // Ready takes priority over a timeout landing in the same cycle.
          if (mmio_ready) begin
            state_r      <= ST_IDLE;
            mmio_valid_r <= 1'b0;
            cmpl_r       <= 1'b1;
            if (mmio_rd_r) begin
              word_r     <= mmio_rdata;
              mmio_rdv_r <= 1'b1;
            end
          end else if (term_s) begin
            state_r      <= ST_IDLE;
            mmio_valid_r <= 1'b0;
            cmpl_r       <= 1'b1;
            bus_err_r    <= 1'b1;
            if (mmio_rd_r) begin
              word_r     <= 32'h0;
              mmio_rdv_r <= 1'b1;
            end
          end else begin
            state_r <= ST_MMIO_WAIT;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomized bench for dmem_access_ctrl against a transaction-level model
// with its own word memory and an emulated BRAM / MMIO device.
module tb_dmem_access_ctrl;

  localparam int          TO     = 16;
  localparam logic [31:0] MBASE  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] addr;
  logic [2:0]  funct3;
  logic [3:0]  web_in;
  logic [31:0] dib_in;
  logic        enb;
  logic [3:0]  web;
  logic [11:0] addrb;
  logic [31:0] dib;
  logic [31:0] doutb;
  logic        mmio_valid;
  logic [3:0]  mmio_we;
  logic [31:0] mmio_addr, mmio_wdata, mmio_rdata;
  logic        mmio_ready;
  logic        stall;
  logic [31:0] DMEM_word;
  logic [1:0]  byte_offset_q;
  logic [2:0]  funct3_q;
  logic        rd_valid, misaligned, bus_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] bram    [0:4095];
  logic [31:0] ref_mem [0:4095];
  logic [31:0] last_word;
  logic [1:0]  last_boff;
  logic [2:0]  last_f3;

  dmem_access_ctrl #(.DMEM_AW(12), .MMIO_BASE(MBASE), .MMIO_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .funct3(funct3), .web_in(web_in), .dib_in(dib_in),
    .enb(enb), .web(web), .addrb(addrb), .dib(dib), .doutb(doutb),
    .mmio_valid(mmio_valid), .mmio_we(mmio_we), .mmio_addr(mmio_addr),
    .mmio_wdata(mmio_wdata), .mmio_rdata(mmio_rdata), .mmio_ready(mmio_ready),
    .stall(stall), .DMEM_word(DMEM_word), .byte_offset_q(byte_offset_q),
    .funct3_q(funct3_q), .rd_valid(rd_valid), .misaligned(misaligned),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // BRAM port B emulation: byte-masked write, read-first, one-cycle read latency.
  always @(posedge clk) begin
    if (enb) begin
      for (int i = 0; i < 4; i++) begin
        if (web[i]) bram[addrb][i*8 +: 8] <= dib[i*8 +: 8];
      end
      doutb <= bram[addrb];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  task automatic idle_check();
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0; mmio_ready = 1'b0;
    @(negedge clk);
    check_eq("idle_rd_valid", rd_valid, 1'b0);
    check_eq("idle_stall", stall, 1'b0);
    check_eq("idle_bus_err", bus_err, 1'b0);
    check_eq("hold_word", DMEM_word, last_word);
    check_eq("hold_boff", byte_offset_q, last_boff);
    check_eq("hold_f3", funct3_q, last_f3);
  endtask

  // One MEM-stage instruction; lat is the wait cycle on which ready rises (> TO: never).
  task automatic do_txn(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [2:0] f3, input logic [31:0] d, input int lat);
    logic [3:0]  we;
    logic [31:0] rdat, exp_w;
    bit mis, mm, tmo;
    int waitc;
    we   = lane_mask(f3, a[1:0]);
    mis  = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
    mm   = (a >= MBASE);
    rdat = $urandom;
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; addr = a; funct3 = f3;
    web_in = wr ? we : 4'h0; dib_in = d; mmio_rdata = rdat; mmio_ready = 1'b0;
    @(negedge clk);
    check_eq("misaligned", misaligned, mis);
    check_eq("enb", enb, !mis && !mm);
    check_eq("stall_req", stall, !mis && (mm || !wr));
    if (!mis && !mm) begin
      check_eq("addrb", addrb, a[13:2]);
      check_eq("web", web, wr ? we : 4'h0);
      if (wr) begin
        check_eq("dib", dib, d);
        for (int i = 0; i < 4; i++)
          if (we[i]) ref_mem[a[13:2]][i*8 +: 8] = d[i*8 +: 8];
      end else begin
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("ld_rd_valid", rd_valid, 1'b1);
        check_eq("ld_word", DMEM_word, ref_mem[a[13:2]]);
        check_eq("ld_boff", byte_offset_q, a[1:0]);
        check_eq("ld_f3", funct3_q, f3);
        check_eq("ld_stall", stall, 1'b0);
        last_word = ref_mem[a[13:2]]; last_boff = a[1:0]; last_f3 = f3;
      end
    end else if (!mis) begin
      check_eq("mmio_valid_req", mmio_valid, 1'b0);
      tmo   = (lat > TO);
      waitc = tmo ? TO : lat;
      for (int k = 1; k <= waitc; k++) begin
        @(posedge clk); #1;
        mmio_ready = (k == lat);
        @(negedge clk);
        check_eq("mmio_valid_wait", mmio_valid, 1'b1);
        check_eq("mmio_stall_wait", stall, 1'b1);
        check_eq("mmio_rdv_wait", rd_valid, 1'b0);
        if (k == 1) begin
          check_eq("mmio_addr", mmio_addr, a);
          check_eq("mmio_we", mmio_we, wr ? we : 4'h0);
          if (wr) check_eq("mmio_wdata", mmio_wdata, d);
        end
      end
      @(posedge clk); #1;
      mmio_ready = 1'b0;
      @(negedge clk);
      check_eq("mmio_valid_done", mmio_valid, 1'b0);
      check_eq("mmio_stall_done", stall, 1'b0);
      check_eq("mmio_no_reissue", enb | misaligned, 1'b0);
      check_eq("bus_err", bus_err, tmo);
      check_eq("mmio_rd_valid", rd_valid, !wr);
      if (!wr) begin
        exp_w = tmo ? 32'h0 : rdat;
        check_eq("mmio_word", DMEM_word, exp_w);
        check_eq("mmio_boff", byte_offset_q, a[1:0]);
        check_eq("mmio_f3", funct3_q, f3);
        last_word = exp_w; last_boff = a[1:0]; last_f3 = f3;
      end
    end
    idle_check();
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    bit wr, rd;
    for (int i = 0; i < 4096; i++) begin
      bram[i] = 32'h0; ref_mem[i] = 32'h0;
    end
    doutb = 32'h0;
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = 32'h0; funct3 = 3'b000;
    web_in = 4'h0; dib_in = 32'h0; mmio_rdata = 32'h0; mmio_ready = 1'b0;
    last_word = 32'h0; last_boff = 2'b00; last_f3 = 3'b000;
    repeat (2) @(negedge clk);
    check_eq("rst_stall", stall, 1'b0);
    check_eq("rst_enb", enb, 1'b0);
    check_eq("rst_mmio_valid", mmio_valid, 1'b0);
    check_eq("rst_rd_valid", rd_valid, 1'b0);
    check_eq("rst_bus_err", bus_err, 1'b0);
    check_eq("rst_word", DMEM_word, 32'h0);
    check_eq("rst_boff_f3", {byte_offset_q, funct3_q}, 5'h0);
    @(posedge clk); #1; rst = 1'b0;

    do_txn(1'b0, 1'b1, 32'h10, 3'b010, 32'hDEAD_BEEF, 0);
    do_txn(1'b1, 1'b0, 32'h10, 3'b010, 32'h0, 0);
    do_txn(1'b1, 1'b0, 32'h13, 3'b001, 32'h0, 0);
    do_txn(1'b0, 1'b1, 32'h8000_0004, 3'b000, 32'h5A, 3);
    do_txn(1'b1, 1'b0, 32'h8000_0008, 3'b010, 32'h0, TO + 50);
    do_txn(1'b1, 1'b0, 32'h8000_0000, 3'b010, 32'h0, TO);
    do_txn(1'b1, 1'b1, 32'h7FFF_FFFC, 3'b010, 32'h1234_5678, 0);
    do_txn(1'b1, 1'b0, 32'h0000_3FFC, 3'b010, 32'h0, 0);

    // Reset in the middle of an MMIO wait.
    @(posedge clk); #1;
    mem_read = 1'b1; mem_write = 1'b0; addr = 32'h8000_0010; funct3 = 3'b010; web_in = 4'h0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1; mem_read = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_mmio_valid", mmio_valid, 1'b0);
    check_eq("post_rst_stall", stall, 1'b0);
    check_eq("post_rst_rd_valid", rd_valid, 1'b0);
    last_word = 32'h0; last_boff = 2'b00; last_f3 = 3'b000;
    do_txn(1'b1, 1'b0, 32'h10, 3'b010, 32'h0, 0);

    for (int n = 0; n < 150; n++) begin
      wr = $urandom_range(0, 1);
      rd = !wr || ($urandom_range(0, 3) == 0);
      if (wr) f3 = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end
      if ($urandom_range(0, 3) == 0) a = MBASE | ($urandom & 32'h0000_0FFF);
      else a = $urandom_range(0, 1023);
      if ($urandom_range(0, 4) != 0) begin
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
        else if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      do_txn(rd, wr, a, f3, $urandom, $urandom_range(1, TO + 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Data-memory port controller between the MEM-stage load/store unit and the data BRAM port B, plus a small MMIO bus. It consumes the byte-lane write enables and aligned write data from the load/store unit. It sequences single-cycle BRAM accesses and multi-cycle MMIO handshakes, stalling the pipeline while an access is in flight. It returns the raw 32-bit word, together with the registered byte offset and funct3, for load extraction, and flags misaligned accesses.

Parameters:
DMEM_AW, 12, BRAM word-address width (4096 words)
MMIO_BASE, 32'h8000_0000, addresses >= this go to the MMIO bus
MMIO_TIMEOUT, 255, max cycles waiting for mmio_ready before the bus-error flag is raised

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
mem_read  in  1  load request, MEM stage
mem_write  in  1  store request, MEM stage
addr  in  32  byte address (ALU result)
funct3  in  3  load/store width code
web_in  in  4  byte-lane enables from the load/store unit
dib_in  in  32  aligned write data from the load/store unit
enb  out  1  BRAM port-B enable
web  out  4  BRAM byte write enables
addrb  out  DMEM_AW  BRAM word address (addr[DMEM_AW+1:2])
dib  out  32  BRAM write data
doutb  in  32  BRAM read data (valid the cycle after enb)
mmio_valid  out  1  MMIO request strobe
mmio_we  out  4  MMIO byte enables (0 = read)
mmio_addr  out  32  MMIO byte address
mmio_wdata  out  32  MMIO write data
mmio_rdata  in  32  MMIO read data
mmio_ready  in  1  MMIO completion
stall  out  1  freeze PC/IF/ID/EX/MEM registers
DMEM_word  out  32  raw read word for load extraction
byte_offset_q  out  2  registered addr[1:0] of the completed load
funct3_q  out  3  registered funct3 of the completed load
rd_valid  out  1  DMEM_word/byte_offset_q/funct3_q valid (1 cycle)
misaligned  out  1  1-cycle pulse: misaligned access, suppressed
bus_err  out  1  1-cycle pulse: MMIO timeout

Behaviour:
- Request = (mem_read | mem_write) while state IDLE. If both are high, treat as a write; mem_read is ignored.
- Misalignment check, combinational on the request:
  - funct3[1:0]=01 with addr[0]=1 is misaligned.
  - funct3[1:0]=10 with addr[1:0]!=0 is misaligned.
  - On misalignment: enb, web, mmio_valid stay 0; misaligned pulses in the same cycle; no stall; state stays IDLE.
- States: IDLE, BRAM_RD, MMIO_WAIT.
- IDLE, BRAM store (addr < MMIO_BASE):
  - enb=1, web=web_in, dib=dib_in in the same cycle.
  - No stall; state stays IDLE.
- IDLE, BRAM load:
  - enb=1, web=0, stall=1.
  - Latch addr[1:0] and funct3; go to BRAM_RD.
- BRAM_RD:
  - DMEM_word=doutb, rd_valid=1, stall=0; go to IDLE.
  - A load therefore costs exactly one stall cycle.
- IDLE, MMIO access (addr >= MMIO_BASE):
  - Register mmio_addr, mmio_we (web_in, or 0 for a read), mmio_wdata.
  - mmio_valid=1 from the next cycle; stall=1 from the request cycle; go to MMIO_WAIT.
- MMIO_WAIT:
  - mmio_valid held at 1 and a cycle counter increments.
  - On mmio_ready: drop mmio_valid. For a read, DMEM_word=mmio_rdata and rd_valid=1. Drop stall; go to IDLE.
  - If the counter reaches MMIO_TIMEOUT with no mmio_ready: bus_err pulse; DMEM_word=32'h0 and rd_valid=1 for reads; go to IDLE.
  - mmio_ready in the same cycle as the timeout: ready wins, no bus_err.
- While stall=1, new requests are not sampled, because the upstream registers hold.
- DMEM_word, byte_offset_q, funct3_q hold their last values after rd_valid drops.
- Reset (also mid-access):
  - State goes to IDLE; all outputs 0; counter 0.
  - An in-flight MMIO transaction is abandoned; mmio_valid drops the cycle after rst.

Decomposition:
- Shared package: funct3 codes (LB/LH/LW/LBU/LHU/SB/SH/SW), the state encoding, MMIO_BASE.
- Sub-module mmio_timeout_ctr: counter with clear/enable and a terminal flag.

Test Plan:
- SW addr=0x10, dib_in=0xDEADBEEF, web_in=4'b1111 -> same cycle: enb=1, addrb=4, web=4'b1111; stall=0.
- LW addr=0x10 with BRAM holding 0xDEADBEEF -> cycle T: stall=1; T+1: rd_valid=1, DMEM_word=0xDEADBEEF, byte_offset_q=0, stall=0.
- LH addr=0x13 -> misaligned=1 in the same cycle; enb=0; stall=0.
- SB addr=0x8000_0004, web_in=4'b0001, dib_in=0x5A; mmio_ready after 3 cycles -> mmio_valid for 3 cycles; mmio_we=4'b0001; stall high for 4 cycles total.
- MMIO LW with mmio_ready never asserted -> after MMIO_TIMEOUT cycles: bus_err=1, rd_valid=1, DMEM_word=0, stall released.
- rst asserted in MMIO_WAIT -> next cycle: state IDLE, mmio_valid=0, stall=0; a following BRAM LW completes normally.
